// File: rtl/ec_pkg.sv
// Shared widths, opcodes and state/case encodings for the GF(2^7)
// elliptic-curve scalar-multiplication slice.
package ec_pkg;
    localparam int FW      = 7;
    localparam int KW      = 7;
    localparam int POINT_W = 2 * FW;
    localparam int IDX_W   = $clog2(KW);

    localparam logic [POINT_W-1:0] POINT_INF = '0;
    localparam logic PU_OP_ADD = 1'b0;
    localparam logic PU_OP_DBL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DBL,
        DBL_WAIT,
        ADD,
        ADD_WAIT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        LOCAL_ZERO,
        LOCAL_P,
        LOCAL_KEEP,
        REQ_DBL,
        REQ_ADD
    } case_t;

    function automatic logic [FW-1:0] pt_x(input logic [POINT_W-1:0] pt);
        return pt[FW-1:0];
    endfunction

    function automatic logic [FW-1:0] pt_y(input logic [POINT_W-1:0] pt);
        return pt[POINT_W-1:FW];
    endfunction
endpackage

// File: rtl/point_case_detect.sv
// Classifies an accumulate step Q + P into a locally resolvable case or a
// request that needs the external point unit.
module point_case_detect
    import ec_pkg::*;
(
    input  logic [POINT_W-1:0] q,
    input  logic [POINT_W-1:0] p,
    output case_t              kind
);
    always_comb begin
        kind = REQ_ADD;
        if (q == POINT_INF) begin
            kind = LOCAL_P;
        end else if (p == POINT_INF) begin
            kind = LOCAL_KEEP;
        end else if ((pt_x(q) == pt_x(p)) && (pt_y(q) != pt_y(p))) begin
            kind = LOCAL_ZERO;
        end else if (q == p) begin
            kind = REQ_DBL;
        end
    end
endmodule

// File: rtl/ec_scalar_mult.sv
// MSB-first double-and-add controller computing k*P; trivial point cases are
// resolved locally, real field work goes to the point unit via pu_req/pu_ack.
module ec_scalar_mult
    import ec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KW-1:0]      k,
    input  logic [POINT_W-1:0] point,
    output logic               busy,
    output logic               done,
    output logic [POINT_W-1:0] result,
    output logic               pu_req,
    output logic               pu_op,
    output logic [POINT_W-1:0] pu_a,
    output logic [POINT_W-1:0] pu_b,
    input  logic               pu_ack,
    input  logic [POINT_W-1:0] pu_sum
);
    state_t             state_reg, state_next;
    logic [POINT_W-1:0] q_reg, q_next;
    logic [POINT_W-1:0] p_reg, p_next;
    logic [POINT_W-1:0] result_reg, result_next;
    logic [POINT_W-1:0] pu_a_reg, pu_a_next;
    logic [POINT_W-1:0] pu_b_reg, pu_b_next;
    logic [KW-1:0]      k_reg, k_next;
    logic [KW-1:0]      k_shift;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               pu_req_reg, pu_req_next;
    logic               pu_op_reg, pu_op_next;
    logic               dbl_end, bit_end, bit_set;
    case_t              add_kind;

    point_case_detect u_detect (
        .q    (q_reg),
        .p    (p_reg),
        .kind (add_kind)
    );

    assign k_shift = k_reg >> idx_reg;
    assign bit_set = k_shift[0];

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        p_next      = p_reg;
        k_next      = k_reg;
        idx_next    = idx_reg;
        result_next = result_reg;
        pu_req_next = pu_req_reg;
        pu_op_next  = pu_op_reg;
        pu_a_next   = pu_a_reg;
        pu_b_next   = pu_b_reg;
        dbl_end     = 1'b0;
        bit_end     = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // DONE also accepts start so a back-to-back launch is not lost.
                if (start) begin
                    p_next     = point;
                    k_next     = k;
                    q_next     = POINT_INF;
                    idx_next   = IDX_W'(KW - 1);
                    state_next = DBL;
                end else begin
                    state_next = IDLE;
                end
            end
            DBL: begin
                if ((q_reg == POINT_INF) || (pt_x(q_reg) == '0)) begin
                    q_next  = POINT_INF;
                    dbl_end = 1'b1;
                end else begin
                    state_next  = DBL_WAIT;
                    pu_req_next = 1'b1;
                    pu_op_next  = PU_OP_DBL;
                    pu_a_next   = q_reg;
                    pu_b_next   = POINT_INF;
                end
            end
            DBL_WAIT: begin
                if (pu_ack) begin
                    q_next      = pu_sum;
                    pu_req_next = 1'b0;
                    dbl_end     = 1'b1;
                end
            end
            ADD: begin
                case (add_kind)
                    LOCAL_ZERO: begin
                        q_next  = POINT_INF;
                        bit_end = 1'b1;
                    end
                    LOCAL_P: begin
                        q_next  = p_reg;
                        bit_end = 1'b1;
                    end
                    LOCAL_KEEP: begin
                        bit_end = 1'b1;
                    end
                    REQ_DBL: begin
                        state_next  = ADD_WAIT;
                        pu_req_next = 1'b1;
                        pu_op_next  = PU_OP_DBL;
                        pu_a_next   = p_reg;
                        pu_b_next   = POINT_INF;
                    end
                    default: begin
                        state_next  = ADD_WAIT;
                        pu_req_next = 1'b1;
                        pu_op_next  = PU_OP_ADD;
                        pu_a_next   = q_reg;
                        pu_b_next   = p_reg;
                    end
                endcase
            end
            ADD_WAIT: begin
                if (pu_ack) begin
                    q_next      = pu_sum;
                    pu_req_next = 1'b0;
                    bit_end     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (dbl_end) begin
            if (bit_set) begin
                state_next = ADD;
            end else begin
                bit_end = 1'b1;
            end
        end

        // Bit advance is folded into the last cycle of the bit's work.
        if (bit_end) begin
            if (idx_reg == '0) begin
                state_next  = DONE;
                result_next = q_next;
            end else begin
                idx_next   = idx_reg - 1'b1;
                state_next = DBL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            q_reg      <= POINT_INF;
            p_reg      <= POINT_INF;
            k_reg      <= '0;
            idx_reg    <= '0;
            result_reg <= POINT_INF;
            pu_req_reg <= 1'b0;
            pu_op_reg  <= PU_OP_ADD;
            pu_a_reg   <= POINT_INF;
            pu_b_reg   <= POINT_INF;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            p_reg      <= p_next;
            k_reg      <= k_next;
            idx_reg    <= idx_next;
            result_reg <= result_next;
            pu_req_reg <= pu_req_next;
            pu_op_reg  <= pu_op_next;
            pu_a_reg   <= pu_a_next;
            pu_b_reg   <= pu_b_next;
        end
    end

    assign busy   = (state_reg != IDLE) && (state_reg != DONE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign pu_req = pu_req_reg;
    assign pu_op  = pu_op_reg;
    assign pu_a   = pu_a_reg;
    assign pu_b   = pu_b_reg;
endmodule

// File: tb/tb_ec_scalar_mult.sv
// Directed bench for ec_scalar_mult with a GF(2^7) point-unit responder and
// request/result scoreboards.
module tb_ec_scalar_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  k = '0;
    logic [13:0] point = '0;
    logic        busy, done, pu_req, pu_op;
    logic [13:0] result, pu_a, pu_b;
    logic        pu_ack = 1'b0;
    logic [13:0] pu_sum = '0;

    int n_checks = 0;
    int n_fail = 0;
    int resp_delay = 3;
    int resp_cnt = 0;
    int req_seen = 0;
    int exp_nreq = 0;
    logic        stray = 1'b0;
    logic [28:0] resp_first;
    logic [28:0] resp_want;
    logic [28:0] exp_req[$];
    logic [13:0] exp_res[$];

    localparam logic [6:0] CURVE_A = 7'h01;

    ec_scalar_mult dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .k      (k),
        .point  (point),
        .busy   (busy),
        .done   (done),
        .result (result),
        .pu_req (pu_req),
        .pu_op  (pu_op),
        .pu_a   (pu_a),
        .pu_b   (pu_b),
        .pu_ack (pu_ack),
        .pu_sum (pu_sum)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // GF(2^7) with reduction polynomial x^7 + x + 1.
    function automatic logic [6:0] gmul(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] r;
        logic [6:0] aa;
        r = '0;
        aa = a;
        for (int i = 0; i < 7; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[6] ? ((aa << 1) ^ 7'h03) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [6:0] ginv(input logic [6:0] a);
        logic [6:0] r;
        logic [6:0] s;
        r = 7'h01;
        s = a;
        for (int i = 1; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [13:0] pt_add(input logic [13:0] p1, input logic [13:0] p2);
        logic [6:0] x1, y1, x2, y2, lam, x3, y3;
        x1 = p1[6:0]; y1 = p1[13:7];
        x2 = p2[6:0]; y2 = p2[13:7];
        lam = gmul(y1 ^ y2, ginv(x1 ^ x2));
        x3 = gmul(lam, lam) ^ lam ^ x1 ^ x2 ^ CURVE_A;
        y3 = gmul(lam, x1 ^ x3) ^ x3 ^ y1;
        return {y3, x3};
    endfunction

    function automatic logic [13:0] pt_dbl(input logic [13:0] p1);
        logic [6:0] x1, y1, lam, x3, y3;
        x1 = p1[6:0]; y1 = p1[13:7];
        lam = x1 ^ gmul(y1, ginv(x1));
        x3 = gmul(lam, lam) ^ lam ^ CURVE_A;
        y3 = gmul(x1, x1) ^ gmul(lam ^ 7'h01, x3);
        return {y3, x3};
    endfunction

    // Reference double-and-add; queues every point-unit request it expects.
    task automatic model_run(input logic [6:0] kk, input logic [13:0] pp,
                             output logic [13:0] res, output int nreq);
        logic [13:0] q;
        q = '0;
        nreq = 0;
        for (int i = 6; i >= 0; i--) begin
            if (q == 14'h0 || q[6:0] == 7'h0) begin
                q = '0;
            end else begin
                exp_req.push_back({1'b1, q, 14'h0});
                q = pt_dbl(q);
                nreq++;
            end
            if (kk[i]) begin
                if (q == 14'h0) q = pp;
                else if (pp == 14'h0) q = q;
                else if (q[6:0] == pp[6:0] && q[13:7] != pp[13:7]) q = '0;
                else if (q == pp) begin
                    exp_req.push_back({1'b1, pp, 14'h0});
                    q = pt_dbl(pp);
                    nreq++;
                end else begin
                    exp_req.push_back({1'b0, q, pp});
                    q = pt_add(q, pp);
                    nreq++;
                end
            end
        end
        res = q;
    endtask

    // Point-unit responder, acting #1 after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stray) begin
                pu_ack = 1'b1;
                pu_sum = 14'h1555;
                stray = 1'b0;
            end else if (!rst_n) begin
                pu_ack = 1'b0;
                resp_cnt = 0;
            end else if (pu_ack) begin
                pu_ack = 1'b0;
                resp_cnt = 0;
            end else if (pu_req) begin
                if (resp_cnt == 0) begin
                    resp_first = {pu_op, pu_a, pu_b};
                    req_seen++;
                    if (exp_req.size() > 0) begin
                        resp_want = exp_req.pop_front();
                        check("req_operands", resp_first, resp_want);
                    end else begin
                        check("req_unexpected", req_seen, 0);
                    end
                end else begin
                    check("req_stable", {pu_op, pu_a, pu_b}, resp_first);
                end
                if (resp_cnt >= resp_delay) begin
                    pu_sum = pu_op ? pt_dbl(pu_a) : pt_add(pu_a, pu_b);
                    pu_ack = 1'b1;
                end
                resp_cnt++;
            end
        end
    end

    // Called at a negedge: drives start for that cycle, returns in cycle 1.
    task automatic launch(input logic [6:0] kk, input logic [13:0] pp);
        logic [13:0] r;
        int nr;
        model_run(kk, pp, r, nr);
        exp_res.push_back(r);
        exp_nreq = nr;
        req_seen = 0;
        start = 1'b1;
        k = kk;
        point = pp;
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", busy, 1);
    endtask

    // Returns at the negedge of the done cycle.
    task automatic wait_done(input int exp_lat);
        int n;
        bit got;
        n = 1;
        got = 1'b0;
        while (n < 3000 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                check("busy_hold", busy, 1);
                @(negedge clk);
                n++;
            end
        end
        check("done_seen", got, 1);
        if (got) begin
            if (exp_lat >= 0) check("latency", n, exp_lat);
            check("busy_at_done", busy, 0);
            if (exp_res.size() > 0) check("result", result, exp_res.pop_front());
            else check("result_unexpected", result, 14'h3FFF);
            check("req_count", req_seen, exp_nreq);
            check("req_queue_empty", exp_req.size(), 0);
        end
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_pu_req", pu_req, 0);
        check("rst_pu_op", pu_op, 0);
        check("rst_pu_a", pu_a, 0);
        check("rst_pu_b", pu_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(7'd0, 14'h0123);
        wait_done(8);
        @(negedge clk);
        check("done_pulse", done, 0);

        launch(7'd1, 14'h0123);
        wait_done(9);
        check("k1_result", result, 14'h0123);
        @(negedge clk);

        resp_delay = 3;
        launch(7'd3, 14'h0123);
        wait_done(-1);
        @(negedge clk);

        launch(7'd2, 14'h0080);
        wait_done(9);
        check("x0_result", result, 0);
        @(negedge clk);

        resp_delay = 1;
        launch(7'd127, 14'h2A35);
        wait_done(-1);
        @(negedge clk);

        // start while busy is ignored; start on the done cycle is accepted
        resp_delay = 2;
        launch(7'd3, 14'h0123);
        start = 1'b1;
        k = 7'd5;
        point = 14'h1F4B;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1);
        launch(7'd1, 14'h0345);
        wait_done(9);
        @(negedge clk);
        check("chain_done_pulse", done, 0);

        // reset while a double is outstanding, then a stray ack
        resp_delay = 20;
        launch(7'd127, 14'h2A35);
        w = 0;
        while (!pu_req && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("req_reached", pu_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_pu_req", pu_req, 0);
        check("rstmid_result", result, 0);
        check("rstmid_done", done, 0);
        rst_n = 1'b1;
        exp_req.delete();
        exp_res.delete();
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy", busy, 0);
            check("stray_pu_req", pu_req, 0);
            check("stray_result", result, 0);
        end

        resp_delay = 0;
        launch(7'd5, 14'h2A35);
        wait_done(-1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
